mips_multicycle_ctrl: RTL

Multicycle control FSM that sequences the MIPS datapath (PC, IR, register file, ALU, shared instruction/data memory). It issues one control word per cycle: register write enable/dest, ALU source muxes, ALU_op, PC update, and memory read/write. Memory accesses use a ready handshake with a timeout. Decoded subset: R-type (add/sub/and/or/slt), lw, sw, beq, addi, j. Anything else traps.

---
 rtl/mips_multicycle_ctrl.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: one Moore control word per cycle; R/addi/sw 4, lw 5, beq/j 3 cycles plus wait states.
// Memory steps stall on mem_ready up to MEM_TIMEOUT cycles; decode faults and timeouts park in TRAP until reset.
module mips_multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       IorD,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALU_op,
  output logic [1:0] PCSource,
  output logic       instr_retired,
  output logic       illegal_instr,
  output logic       bus_error,
  output logic [3:0] state
);

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_R_EXEC    = 4'd6;
  localparam logic [3:0] S_R_WB      = 4'd7;
  localparam logic [3:0] S_BRANCH    = 4'd8;
  localparam logic [3:0] S_JUMP      = 4'd9;
  localparam logic [3:0] S_ADDI_EXEC = 4'd10;
  localparam logic [3:0] S_ADDI_WB   = 4'd11;
  localparam logic [3:0] S_TRAP      = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam bit               TMO_EN   = (MEM_TIMEOUT > 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  logic [3:0]       cur;
  logic [3:0]       nxt;
  logic [CNT_W-1:0] cnt;
  logic             ill_q;
  logic             bus_q;
  logic             to_ill;
  logic             to_bus;
  logic             waiting;
  logic             timeout;
  logic             r_ok;

  assign waiting = (cur == S_FETCH) || (cur == S_MEM_READ) || (cur == S_MEM_WRITE);
  // A completing handshake in the last allowed cycle takes priority over the timeout.
  assign timeout = TMO_EN && waiting && !mem_ready && (cnt == CNT_LAST);
  assign r_ok    = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                   (funct == FN_OR)  || (funct == FN_SLT);

  always_comb begin
    nxt    = cur;
    to_ill = 1'b0;
    to_bus = 1'b0;
    case (cur)
      S_FETCH: begin
        if (mem_ready)    nxt = S_DECODE;
        else if (timeout) begin nxt = S_TRAP; to_bus = 1'b1; end
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE: begin
            if (r_ok) nxt = S_R_EXEC;
            else begin nxt = S_TRAP; to_ill = 1'b1; end
          end
          OP_LW, OP_SW: nxt = S_MEM_ADDR;
          OP_BEQ:       nxt = S_BRANCH;
          OP_ADDI:      nxt = S_ADDI_EXEC;
          OP_J:         nxt = S_JUMP;
          default: begin nxt = S_TRAP; to_ill = 1'b1; end
        endcase
      end
      S_MEM_ADDR: nxt = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ: begin
        if (mem_ready)    nxt = S_MEM_WB;
        else if (timeout) begin nxt = S_TRAP; to_bus = 1'b1; end
      end
      S_MEM_WRITE: begin
        if (mem_ready)    nxt = S_FETCH;
        else if (timeout) begin nxt = S_TRAP; to_bus = 1'b1; end
      end
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: nxt = S_FETCH;
      S_R_EXEC:    nxt = S_R_WB;
      S_ADDI_EXEC: nxt = S_ADDI_WB;
      S_TRAP:      nxt = S_TRAP;
      default:     nxt = S_TRAP;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cur   <= S_FETCH;
      cnt   <= '0;
      ill_q <= 1'b0;
      bus_q <= 1'b0;
    end else begin
      cur <= nxt;
      // Any state change restarts the wait count, so each memory step gets a fresh budget.
      if (nxt != cur)
        cnt <= '0;
      else if (waiting && !mem_ready)
        cnt <= cnt + CNT_W'(1);
      if (to_ill) ill_q <= 1'b1;
      if (to_bus) bus_q <= 1'b1;
    end
  end

  always_comb begin
    pc_en         = 1'b0;
    IorD          = 1'b0;
    mem_rd        = 1'b0;
    mem_wr        = 1'b0;
    IRWrite       = 1'b0;
    RegDst        = 1'b0;
    MemtoReg      = 1'b0;
    RegWrite      = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    ALU_op        = 4'b0000;
    PCSource      = 2'b00;
    instr_retired = 1'b0;
    // Outputs are forced quiet while reset is held so an aborted store never reaches memory.
    if (rstn) begin
      ALU_op = ALU_ADD;
      case (cur)
        S_FETCH: begin
          mem_rd  = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          pc_en   = mem_ready;
        end
        S_DECODE:   ALUSrcB = 2'b11;
        S_MEM_ADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_MEM_READ: begin
          mem_rd = 1'b1;
          IorD   = 1'b1;
        end
        S_MEM_WB: begin
          RegWrite      = 1'b1;
          MemtoReg      = 1'b1;
          instr_retired = 1'b1;
        end
        S_MEM_WRITE: begin
          mem_wr        = 1'b1;
          IorD          = 1'b1;
          instr_retired = mem_ready;
        end
        S_R_EXEC: begin
          ALUSrcA = 1'b1;
          case (funct)
            FN_SUB:  ALU_op = ALU_SUB;
            FN_AND:  ALU_op = ALU_AND;
            FN_OR:   ALU_op = ALU_OR;
            FN_SLT:  ALU_op = ALU_SLT;
            default: ALU_op = ALU_ADD;
          endcase
        end
        S_R_WB: begin
          RegWrite      = 1'b1;
          RegDst        = 1'b1;
          instr_retired = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA       = 1'b1;
          ALU_op        = ALU_SUB;
          PCSource      = 2'b01;
          pc_en         = alu_zero;
          instr_retired = 1'b1;
        end
        S_JUMP: begin
          PCSource      = 2'b10;
          pc_en         = 1'b1;
          instr_retired = 1'b1;
        end
        S_ADDI_EXEC: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_ADDI_WB: begin
          RegWrite      = 1'b1;
          instr_retired = 1'b1;
        end
        default: ALU_op = 4'b0000;
      endcase
    end
  end

  assign illegal_instr = ill_q;
  assign bus_error     = bus_q;
  assign state         = cur;

endmodule
